// File: rtl/rfid_frame_rx.sv
// RFID reader frame receiver: parses STX/TAG/CHK/ETX frames from the UART byte
// stream, enforces an inter-byte timeout and suppresses repeated tags.
module rfid_frame_rx #(
  parameter logic [7:0]  STX            = 8'h02,
  parameter logic [7:0]  ETX            = 8'h03,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned HOLDOFF_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] rfid_out,
  output logic       submit,
  output logic       frame_err,
  output logic       dup_drop,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {IDLE, GET_TAG, GET_CHK, GET_ETX} state_t;

  state_t        state_q, state_d;
  logic [7:0]    tag_q, tag_d;
  logic [7:0]    rfid_q, rfid_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          submit_q, submit_d;
  logic          err_q, err_d;
  logic          dup_q, dup_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tag_q    <= 8'h00;
      rfid_q   <= 8'h00;
      tmo_q    <= '0;
      hold_q   <= '0;
      submit_q <= 1'b0;
      err_q    <= 1'b0;
      dup_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      rfid_q   <= rfid_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
      submit_q <= submit_d;
      err_q    <= err_d;
      dup_q    <= dup_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    rfid_d   = rfid_q;
    tmo_d    = '0;
    hold_d   = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
    submit_d = 1'b0;
    err_d    = 1'b0;
    dup_d    = 1'b0;

    if (byte_valid) begin
      // An arriving byte always beats a timeout expiring on the same edge.
      case (state_q)
        IDLE: begin
          if (byte_in == STX) state_d = GET_TAG;
        end
        GET_TAG: begin
          tag_d   = byte_in;
          state_d = GET_CHK;
        end
        GET_CHK: begin
          if (byte_in == ~tag_q) begin
            state_d = GET_ETX;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        GET_ETX: begin
          state_d = IDLE;
          if (byte_in != ETX) begin
            err_d = 1'b1;
          end else if (hold_q != '0 && tag_q == rfid_q) begin
            dup_d = 1'b1;
          end else begin
            rfid_d   = tag_q;
            submit_d = 1'b1;
            hold_d   = HOLD_LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign rfid_out  = rfid_q;
  assign submit    = submit_q;
  assign frame_err = err_q;
  assign dup_drop  = dup_q;
  assign busy      = busy_q;

endmodule
